// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station.
// Holds the word typedefs, the Source / AluInstr / CompleteEntry messages,
// the default depth, and the flat bit widths used on module ports.
// A Source whose valid bit is 0 carries its producer tag in value[15:0].
// Once the source is woken, value is overwritten with the result data.
package alu_reservation_station_pkg;

    typedef logic [7:0]  w8;
    typedef logic [15:0] w16;
    typedef logic [31:0] w32;

    typedef struct packed {
        logic valid;
        w32   value;
    } Source;

    typedef struct packed {
        w8     op;
        w16    commit_id;
        w16    dest_phys;
        Source src1;
        Source src2;
    } AluInstr;

    // kind == 0 marks a register writeback that may wake waiting sources.
    typedef struct packed {
        logic kind;
        w16   dest_phys;
        w32   data;
    } CompleteEntry;

    localparam int RS_DEPTH_DEFAULT = 8;

    localparam int SOURCE_W         = $bits(Source);
    localparam int ALU_INSTR_W      = $bits(AluInstr);
    localparam int COMPLETE_ENTRY_W = $bits(CompleteEntry);

endpackage

// File: rtl/alu_reservation_station_rs_wakeup.sv
// rs_wakeup: combinational operand wake-up for a single source.
// Ports:
//   src_in        source as stored or as it arrives from decode
//   complete_en   broadcast valid
//   complete_msg  CompleteEntry broadcast
//   src_out       src_in, or the woken version of it when the broadcast matches
module rs_wakeup
    import alu_reservation_station_pkg::*;
(
    input  logic [SOURCE_W-1:0]         src_in,
    input  logic                        complete_en,
    input  logic [COMPLETE_ENTRY_W-1:0] complete_msg,
    output logic [SOURCE_W-1:0]         src_out
);

    Source        s_in;
    Source        s_out;
    CompleteEntry cplt;

    always_comb begin
        s_in  = src_in;
        cplt  = complete_msg;
        s_out = s_in;
        // Only sources that are still waiting hold a tag. A valid source's value is data.
        if (complete_en && !cplt.kind && !s_in.valid && (cplt.dest_phys == s_in.value[15:0])) begin
            s_out.valid = 1'b1;
            s_out.value = cplt.data;
        end
    end

    assign src_out = s_out;

endmodule

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: buffers decoded ALU instructions until both
// operands are valid, then issues the oldest ready one through an output register.
// Ports:
//   clock, reset (async, active-high), flash (sync flush)
//   alu_instr_en/msg/reject          dispatch from decode
//   complete_info_en/msg/reject      result broadcast (reject tied 0)
//   issue_en/msg/reject              to the ALU
// Storage is a collapsing age-ordered queue. Slot 0 is the oldest entry, and
// slots [0,count) are valid.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flash,
    input  logic                        alu_instr_en,
    input  logic [ALU_INSTR_W-1:0]      alu_instr_msg,
    output logic                        alu_instr_reject,
    input  logic                        complete_info_en,
    input  logic [COMPLETE_ENTRY_W-1:0] complete_info_msg,
    output logic                        complete_info_reject,
    output logic                        issue_en,
    output logic [ALU_INSTR_W-1:0]      issue_msg,
    input  logic                        issue_reject
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    AluInstr              slot_q  [DEPTH];
    AluInstr              slot_wk [DEPTH];
    AluInstr              slot_d  [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     valid_d;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic [CNT_W-1:0]     count_after_sel;
    AluInstr              out_q;
    logic                 out_valid_q;

    logic [SOURCE_W-1:0]  wk1 [DEPTH];
    logic [SOURCE_W-1:0]  wk2 [DEPTH];
    logic [SOURCE_W-1:0]  in_wk1;
    logic [SOURCE_W-1:0]  in_wk2;
    AluInstr              in_instr;
    AluInstr              in_wk;

    logic [DEPTH-1:0]     ready;
    logic                 sel_hit;
    logic [IDX_W-1:0]     sel_idx;
    logic                 can_load;
    logic                 sel_valid;
    logic                 enq;

    assign complete_info_reject = 1'b0;
    assign alu_instr_reject     = (count_q == CNT_W'(DEPTH));
    assign issue_en             = out_valid_q;
    assign issue_msg            = out_q;

    // Wake-up for every stored source and for both incoming sources.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot_wk
        rs_wakeup u_wk_src1 (
            .src_in       (slot_q[g].src1),
            .complete_en  (complete_info_en),
            .complete_msg (complete_info_msg),
            .src_out      (wk1[g])
        );
        rs_wakeup u_wk_src2 (
            .src_in       (slot_q[g].src2),
            .complete_en  (complete_info_en),
            .complete_msg (complete_info_msg),
            .src_out      (wk2[g])
        );
    end

    assign in_instr = alu_instr_msg;

    rs_wakeup u_wk_in_src1 (
        .src_in       (in_instr.src1),
        .complete_en  (complete_info_en),
        .complete_msg (complete_info_msg),
        .src_out      (in_wk1)
    );
    rs_wakeup u_wk_in_src2 (
        .src_in       (in_instr.src2),
        .complete_en  (complete_info_en),
        .complete_msg (complete_info_msg),
        .src_out      (in_wk2)
    );

    always_comb begin
        in_wk      = in_instr;
        in_wk.src1 = in_wk1;
        in_wk.src2 = in_wk2;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_wk[i]      = slot_q[i];
            slot_wk[i].src1 = wk1[i];
            slot_wk[i].src2 = wk2[i];
        end
    end

    // Readiness uses registered state only, so a same-cycle wake-up issues one cycle later.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] & slot_q[i].src1.valid & slot_q[i].src2.valid;
        end
    end

    // First-one finder. The lowest index is the oldest entry.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_hit = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    // While the ALU is refusing the current output, hold it and take nothing from the queue.
    assign can_load        = !(out_valid_q && issue_reject);
    assign sel_valid       = can_load && sel_hit;
    assign enq             = alu_instr_en && !alu_instr_reject;
    assign count_after_sel = count_q - CNT_W'(sel_valid);
    assign count_d         = count_after_sel + CNT_W'(enq);

    // Collapse above the selected slot, then append the new entry at the new tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_wk[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (sel_valid && (i >= int'(sel_idx))) begin
                slot_d[i] = slot_wk[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (enq && (count_after_sel == CNT_W'(i))) begin
                slot_d[i] = in_wk;
            end
            valid_d[i] = (CNT_W'(i) < count_d);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else if (flash) begin
            count_q     <= '0;
            valid_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            if (can_load) begin
                out_valid_q <= sel_hit;
                if (sel_hit) begin
                    out_q <= slot_q[sel_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for alu_reservation_station.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that same point.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic                        clock;
    logic                        reset;
    logic                        flash;
    logic                        alu_instr_en;
    logic [ALU_INSTR_W-1:0]      alu_instr_msg;
    logic                        alu_instr_reject;
    logic                        complete_info_en;
    logic [COMPLETE_ENTRY_W-1:0] complete_info_msg;
    logic                        complete_info_reject;
    logic                        issue_en;
    logic [ALU_INSTR_W-1:0]      issue_msg;
    logic                        issue_reject;

    AluInstr iss;
    assign iss = issue_msg;

    int checks = 0;
    int errors = 0;

    alu_reservation_station #(.DEPTH(8)) dut (
        .clock                (clock),
        .reset                (reset),
        .flash                (flash),
        .alu_instr_en         (alu_instr_en),
        .alu_instr_msg        (alu_instr_msg),
        .alu_instr_reject     (alu_instr_reject),
        .complete_info_en     (complete_info_en),
        .complete_info_msg    (complete_info_msg),
        .complete_info_reject (complete_info_reject),
        .issue_en             (issue_en),
        .issue_msg            (issue_msg),
        .issue_reject         (issue_reject)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic AluInstr mk(input w16 cid, input logic v1, input w32 s1,
                                   input logic v2, input w32 s2);
        AluInstr a;
        a.op         = 8'h01;
        a.commit_id  = cid;
        a.dest_phys  = cid;
        a.src1.valid = v1;
        a.src1.value = s1;
        a.src2.valid = v2;
        a.src2.value = s2;
        return a;
    endfunction

    function automatic CompleteEntry mkc(input logic kind, input w16 dest, input w32 data);
        CompleteEntry c;
        c.kind      = kind;
        c.dest_phys = dest;
        c.data      = data;
        return c;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset             = 1'b1;
        flash             = 1'b0;
        alu_instr_en      = 1'b0;
        alu_instr_msg     = '0;
        complete_info_en  = 1'b0;
        complete_info_msg = '0;
        issue_reject      = 1'b0;
        #2;
        check("rst_issue_en", issue_en, 0);
        check("rst_reject", alu_instr_reject, 0);
        check("rst_count", dut.count_q, 0);
        check("rst_cplt_reject", complete_info_reject, 0);
        step();
        reset = 1'b0;
        step();

        // T1: both sources valid -> issue after the second edge
        alu_instr_en  = 1'b1;
        alu_instr_msg = mk(16'h0101, 1'b1, 32'd5, 1'b1, 32'd7);
        step();
        alu_instr_en = 1'b0;
        check("t1_not_yet", issue_en, 0);
        step();
        check("t1_issue_en", issue_en, 1);
        check("t1_src1", iss.src1.value, 5);
        check("t1_src2", iss.src2.value, 7);
        check("t1_commit", iss.commit_id, 16'h0101);
        step();
        check("t1_drained", issue_en, 0);

        // T2: stored wake-up
        alu_instr_en  = 1'b1;
        alu_instr_msg = mk(16'h0202, 1'b1, 32'd1, 1'b0, 32'h0000_0012);
        step();
        alu_instr_en = 1'b0;
        step();
        step();
        check("t2_waiting", issue_en, 0);
        complete_info_en  = 1'b1;
        complete_info_msg = mkc(1'b0, 16'h0012, 32'hDEAD_BEEF);
        step();
        complete_info_en = 1'b0;
        check("t2_one_edge", issue_en, 0);
        step();
        check("t2_issue_en", issue_en, 1);
        check("t2_src2", iss.src2.value, 32'hDEAD_BEEF);
        check("t2_src2_valid", iss.src2.valid, 1);
        check("t2_commit", iss.commit_id, 16'h0202);
        step();
        check("t2_drained", issue_en, 0);

        // Enqueue wake-up: the broadcast arrives in the same cycle as the dispatch
        alu_instr_en      = 1'b1;
        alu_instr_msg     = mk(16'h0303, 1'b0, 32'h0000_0040, 1'b1, 32'd9);
        complete_info_en  = 1'b1;
        complete_info_msg = mkc(1'b0, 16'h0040, 32'h0000_4444);
        step();
        alu_instr_en     = 1'b0;
        complete_info_en = 1'b0;
        check("t2c_not_yet", issue_en, 0);
        step();
        check("t2c_issue_en", issue_en, 1);
        check("t2c_src1", iss.src1.value, 32'h4444);
        step();

        // T3a: the younger entry woken first issues first
        alu_instr_en  = 1'b1;
        alu_instr_msg = mk(16'h000A, 1'b1, 32'd2, 1'b0, 32'h0000_0020);
        step();
        alu_instr_msg = mk(16'h000B, 1'b1, 32'd3, 1'b0, 32'h0000_0021);
        step();
        alu_instr_en = 1'b0;
        // A non-register completion (kind=1) must not wake tag 0x20
        complete_info_en  = 1'b1;
        complete_info_msg = mkc(1'b1, 16'h0020, 32'h1111_1111);
        step();
        complete_info_msg = mkc(1'b0, 16'h0021, 32'h2121_0000);
        step();
        check("t3_kind_no_wake", issue_en, 0);
        complete_info_msg = mkc(1'b0, 16'h0020, 32'h2020_0000);
        step();
        complete_info_en = 1'b0;
        check("t3a_first_en", issue_en, 1);
        check("t3a_first_is_b", iss.commit_id, 16'h000B);
        step();
        check("t3a_second_is_a", iss.commit_id, 16'h000A);
        check("t3a_a_src2", iss.src2.value, 32'h2020_0000);
        step();
        check("t3a_drained", issue_en, 0);

        // T3b: both woken in the same cycle -> the older entry issues first
        alu_instr_en  = 1'b1;
        alu_instr_msg = mk(16'h001A, 1'b1, 32'd4, 1'b0, 32'h0000_0030);
        step();
        alu_instr_msg = mk(16'h001B, 1'b0, 32'h0000_0030, 1'b1, 32'd6);
        step();
        alu_instr_en      = 1'b0;
        complete_info_en  = 1'b1;
        complete_info_msg = mkc(1'b0, 16'h0030, 32'h3030_3030);
        step();
        complete_info_en = 1'b0;
        step();
        check("t3b_first_is_a", iss.commit_id, 16'h001A);
        step();
        check("t3b_second_is_b", iss.commit_id, 16'h001B);
        check("t3b_b_src1", iss.src1.value, 32'h3030_3030);
        step();
        check("t3b_drained", issue_en, 0);

        // T4: backpressure. The output register absorbs the first entry, so
        // nine dispatches are accepted and the tenth sees a full queue.
        issue_reject = 1'b1;
        for (int k = 0; k < 10; k++) begin
            alu_instr_en  = 1'b1;
            alu_instr_msg = mk(16'(k), 1'b1, 32'(k), 1'b1, 32'(k + 100));
            check($sformatf("t4_reject_%0d", k), alu_instr_reject, (k == 9) ? 1 : 0);
            step();
        end
        alu_instr_en = 1'b0;
        check("t4_count_full", dut.count_q, 8);
        check("t4_reject_held", alu_instr_reject, 1);
        check("t4_out_held", iss.commit_id, 0);
        step();
        check("t4_out_stable", iss.commit_id, 0);
        check("t4_en_stable", issue_en, 1);
        issue_reject = 1'b0;
        for (int j = 0; j < 9; j++) begin
            check($sformatf("t4_drain_en_%0d", j), issue_en, 1);
            check($sformatf("t4_drain_id_%0d", j), iss.commit_id, j);
            check($sformatf("t4_drain_src2_%0d", j), iss.src2.value, j + 100);
            step();
        end
        check("t4_empty_en", issue_en, 0);
        check("t4_empty_count", dut.count_q, 0);

        // T5: flush with five entries queued and the output stalled
        issue_reject = 1'b1;
        for (int k = 0; k < 6; k++) begin
            alu_instr_en  = 1'b1;
            alu_instr_msg = mk(16'(16'h0040 + k), 1'b1, 32'd1, 1'b1, 32'd2);
            step();
        end
        check("t5_count5", dut.count_q, 5);
        check("t5_issue_en", issue_en, 1);
        flash         = 1'b1;
        alu_instr_msg = mk(16'h0099, 1'b1, 32'd1, 1'b1, 32'd2);
        step();
        flash        = 1'b0;
        alu_instr_en = 1'b0;
        check("t5_flush_en", issue_en, 0);
        check("t5_flush_reject", alu_instr_reject, 0);
        check("t5_flush_count", dut.count_q, 0);
        issue_reject  = 1'b0;
        alu_instr_en  = 1'b1;
        alu_instr_msg = mk(16'h0055, 1'b1, 32'd8, 1'b1, 32'd9);
        step();
        alu_instr_en = 1'b0;
        check("t5_post_not_yet", issue_en, 0);
        step();
        check("t5_post_en", issue_en, 1);
        check("t5_post_id", iss.commit_id, 16'h0055);
        step();

        // T6: async reset between edges
        issue_reject  = 1'b1;
        alu_instr_en  = 1'b1;
        alu_instr_msg = mk(16'h0061, 1'b1, 32'd1, 1'b1, 32'd1);
        step();
        alu_instr_msg = mk(16'h0062, 1'b1, 32'd1, 1'b1, 32'd1);
        step();
        alu_instr_en = 1'b0;
        check("t6_pre_en", issue_en, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_en", issue_en, 0);
        check("t6_async_count", dut.count_q, 0);
        step();
        reset        = 1'b0;
        issue_reject = 1'b0;
        check("t6_rel_reject", alu_instr_reject, 0);
        alu_instr_en  = 1'b1;
        alu_instr_msg = mk(16'h0077, 1'b1, 32'd3, 1'b1, 32'd4);
        step();
        alu_instr_en = 1'b0;
        check("t6_rel_count", dut.count_q, 1);
        step();
        check("t6_rel_en", issue_en, 1);
        check("t6_rel_id", iss.commit_id, 16'h0077);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
